// File: rtl/req_frontend_pkg.sv
// Shared types and defaults for the two-channel request front end.
package req_frontend_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int LEN_W_DEF = 4;

    // A zero length field encodes the largest burst the field can describe.
    localparam int MAX_BEATS = 1 << LEN_W_DEF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } chan_state_e;

endpackage

// File: rtl/req_frontend_chan.sv
// One request channel: burst command queue, request FSM and beat counter.
module req_chan
    import req_frontend_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [LEN_W-1:0] len,
    output logic             full,
    input  logic             beat,
    output logic             req,
    input  logic             gnt,
    output logic             done,
    output logic             err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REM_W = LEN_W + 1;
    localparam logic [REM_W-1:0] FULL_BURST = REM_W'(1) << LEN_W;

    logic [LEN_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [LEN_W-1:0] head;
    logic [REM_W-1:0] remaining;
    logic [1:0]       rel_gnt;
    chan_state_e      state;
    chan_state_e      state_nxt;
    logic             pop;
    logic             push_ok;
    logic             beat_ok;
    logic             last_beat;

    // A push into a full queue still lands when the FSM pops in the same cycle.
    assign full      = (count == CNT_W'(DEPTH));
    assign head      = mem[rd_ptr];
    assign pop       = (state == IDLE) && (count != '0);
    assign push_ok   = push && (!full || pop);
    assign beat_ok   = gnt && beat && ((state == REQ) || (state == XFER));
    assign last_beat = beat_ok && (remaining == REM_W'(1));

    // Queue storage: payload only, no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= len;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FSM state register; reset drops req without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next state; the final beat may arrive in the first granted REQ cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (count != '0) state_nxt = REQ;
            REQ:     if (last_beat) state_nxt = RELEASE;
                     else if (gnt)  state_nxt = XFER;
            XFER:    if (last_beat) state_nxt = RELEASE;
            RELEASE: if (!gnt)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: req follows the registered state directly.
    always_comb begin
        req = (state == REQ) || (state == XFER);
    end

    // Beats left in the current burst; loaded as the head command is popped.
    always_ff @(posedge clk) begin
        if (pop) begin
            remaining <= (head == '0) ? FULL_BURST : {1'b0, head};
        end else if (beat_ok) begin
            remaining <= remaining - 1'b1;
        end
    end

    // Completion pulse, release-grant watchdog and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done    <= 1'b0;
            err     <= 1'b0;
            rel_gnt <= '0;
        end else begin
            done <= last_beat;
            if ((state == RELEASE) && gnt) begin
                if (rel_gnt != 2'd2) rel_gnt <= rel_gnt + 1'b1;
            end else begin
                rel_gnt <= '0;
            end
            if ((push && !push_ok) ||
                ((state == IDLE) && gnt) ||
                ((state == RELEASE) && gnt && (rel_gnt == 2'd2))) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_frontend.sv
// Two independent request channels feeding the downstream two-client arbiter.
module req_frontend
    import req_frontend_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push0,
    input  logic [LEN_W-1:0] len0,
    output logic             full0,
    input  logic             beat0,
    output logic             req0,
    input  logic             gnt0,
    output logic             done0,
    output logic             err0,
    input  logic             push1,
    input  logic [LEN_W-1:0] len1,
    output logic             full1,
    input  logic             beat1,
    output logic             req1,
    input  logic             gnt1,
    output logic             done1,
    output logic             err1
);

    req_chan #(.DEPTH(DEPTH), .LEN_W(LEN_W)) u_ch0 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push0),
        .len   (len0),
        .full  (full0),
        .beat  (beat0),
        .req   (req0),
        .gnt   (gnt0),
        .done  (done0),
        .err   (err0)
    );

    req_chan #(.DEPTH(DEPTH), .LEN_W(LEN_W)) u_ch1 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push1),
        .len   (len1),
        .full  (full1),
        .beat  (beat1),
        .req   (req1),
        .gnt   (gnt1),
        .done  (done1),
        .err   (err1)
    );

endmodule

// File: tb/tb_req_frontend.sv
// Bench for req_frontend: directed scenarios with random beats/pushes against a burst-level model.
module tb_req_frontend;
    import req_frontend_pkg::*;

    localparam int DEPTH = DEPTH_DEF;
    localparam int LEN_W = LEN_W_DEF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic             push_v [2];
    logic             beat_v [2];
    logic             gnt_v  [2];
    logic [LEN_W-1:0] len_v  [2];
    logic full0, full1, req0, req1, done0, done1, err0, err1;

    always #5 clk = ~clk;

    req_frontend #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .push0 (push_v[0]),
        .len0  (len_v[0]),
        .full0 (full0),
        .beat0 (beat_v[0]),
        .req0  (req0),
        .gnt0  (gnt_v[0]),
        .done0 (done0),
        .err0  (err0),
        .push1 (push_v[1]),
        .len1  (len_v[1]),
        .full1 (full1),
        .beat1 (beat_v[1]),
        .req1  (req1),
        .gnt1  (gnt_v[1]),
        .done1 (done1),
        .err1  (err1)
    );

    // Burst-level reference: pending lengths, whether a burst owns the channel,
    // beats still owed, and whether we are waiting for the grant to go away.
    int mq [2][$];
    bit mact [2];
    bit mdrain [2];
    bit mdone [2];
    bit merr [2];
    bit mprev [2];
    int mleft [2];
    int mgh [2];

    int checks = 0;
    int errors = 0;
    int dut_done [2];
    int dut_beats [2];
    int bprob [2];
    int arb_mode;
    int owner;

    function automatic logic req_of(int c);
        return (c == 0) ? req0 : req1;
    endfunction

    function automatic logic done_of(int c);
        return (c == 0) ? done0 : done1;
    endfunction

    function automatic bit model_idle(int c);
        return (mq[c].size() == 0) && !mact[c] && !mdrain[c];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            mq[c].delete();
            mact[c] = 0; mdrain[c] = 0; mdone[c] = 0; merr[c] = 0;
            mprev[c] = 0; mleft[c] = 0; mgh[c] = 0;
        end
    endtask

    task automatic model_update();
        for (int c = 0; c < 2; c++) begin
            bit full_pre;
            bit popped;
            int l;
            full_pre = (mq[c].size() == DEPTH);
            popped = 0;
            mdone[c] = 0;
            if (!mact[c] && !mdrain[c]) begin
                if (gnt_v[c]) merr[c] = 1;
                if (mq[c].size() > 0) begin
                    l = mq[c].pop_front();
                    mleft[c] = (l == 0) ? MAX_BEATS : l;
                    mact[c] = 1;
                    popped = 1;
                end
            end else if (mact[c]) begin
                if (gnt_v[c] && beat_v[c]) begin
                    if (mleft[c] == 1) begin
                        mact[c] = 0; mdrain[c] = 1; mgh[c] = 0; mdone[c] = 1;
                    end else begin
                        mleft[c] = mleft[c] - 1;
                    end
                end
            end else begin
                if (gnt_v[c]) begin
                    mgh[c] = mgh[c] + 1;
                    if (mgh[c] > 2) merr[c] = 1;
                end else begin
                    mdrain[c] = 0; mgh[c] = 0;
                end
            end
            if (push_v[c]) begin
                if (!full_pre || popped) mq[c].push_back(int'(len_v[c]));
                else merr[c] = 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("req0", req0, mact[0]);
        chk("req1", req1, mact[1]);
        chk("done0", done0, mdone[0]);
        chk("done1", done1, mdone[1]);
        chk("full0", full0, mq[0].size() == DEPTH);
        chk("full1", full1, mq[1].size() == DEPTH);
        chk("err0", err0, merr[0]);
        chk("err1", err1, merr[1]);
    endtask

    // Arbiter stand-in: 0 = manual, 1 = grant one cycle after req, 2 = one owner at a time.
    task automatic arbitrate();
        if (arb_mode == 1) begin
            for (int c = 0; c < 2; c++) gnt_v[c] = mprev[c];
        end else if (arb_mode == 2) begin
            if (owner >= 0 && !mact[owner]) owner = -1;
            if (owner < 0) begin
                if (mact[0]) owner = 0;
                else if (mact[1]) owner = 1;
            end
            for (int c = 0; c < 2; c++) gnt_v[c] = (owner == c);
        end
    endtask

    task automatic step();
        bit pr [2];
        for (int c = 0; c < 2; c++) begin
            beat_v[c] = ($urandom_range(0, 99) < bprob[c]);
        end
        arbitrate();
        for (int c = 0; c < 2; c++) begin
            if (req_of(c) && gnt_v[c] && beat_v[c]) dut_beats[c]++;
            pr[c] = mact[c];
        end
        @(posedge clk);
        if (rst_n) model_update();
        else model_reset();
        if (rst_n) begin
            for (int c = 0; c < 2; c++) mprev[c] = pr[c];
        end
        #1;
        check_outputs();
        for (int c = 0; c < 2; c++) begin
            if (done_of(c)) dut_done[c]++;
            push_v[c] = 1'b0;
        end
    endtask

    task automatic wait_idle(input int c, input int limit);
        int k;
        k = 0;
        while (!model_idle(c) && k < limit) begin
            step();
            k++;
        end
        chk("idle_bound", k < limit, 1'b1);
    endtask

    task automatic async_reset(input int hold);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_req0", req0, 1'b0);
        chk("rst_req1", req1, 1'b0);
        chk("rst_done0", done0, 1'b0);
        chk("rst_err0", err0, 1'b0);
        chk("rst_err1", err1, 1'b0);
        chk("rst_full0", full0, 1'b0);
        for (int c = 0; c < 2; c++) gnt_v[c] = 1'b0;
        repeat (hold) step();
        rst_n = 1'b1;
    endtask

    int b0, d0, d1, k;

    initial begin
        for (int c = 0; c < 2; c++) begin
            push_v[c] = 0; beat_v[c] = 0; gnt_v[c] = 0; len_v[c] = '0;
            dut_done[c] = 0; dut_beats[c] = 0; bprob[c] = 0;
        end
        arb_mode = 0;
        owner = -1;
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Single command, len 3, grant one cycle after req, beat every cycle.
        arb_mode = 1; bprob[0] = 100; bprob[1] = 0;
        b0 = dut_beats[0]; d0 = dut_done[0];
        push_v[0] = 1; len_v[0] = 4'd3;
        step();
        chk("t1_req_early", req0, 1'b0);
        step();
        chk("t1_req_rise", req0, 1'b1);
        wait_idle(0, 50);
        chk_int("t1_beats", dut_beats[0] - b0, 3);
        chk_int("t1_done", dut_done[0] - d0, 1);

        // Back-to-back commands len 1 then len 2.
        b0 = dut_beats[0]; d0 = dut_done[0];
        push_v[0] = 1; len_v[0] = 4'd1;
        step();
        push_v[0] = 1; len_v[0] = 4'd2;
        step();
        wait_idle(0, 60);
        chk_int("t2_beats", dut_beats[0] - b0, 3);
        chk_int("t2_done", dut_done[0] - d0, 2);

        // len 0 with gapped beats: full-size burst.
        bprob[0] = 50;
        b0 = dut_beats[0]; d0 = dut_done[0];
        push_v[0] = 1; len_v[0] = 4'd0;
        step();
        wait_idle(0, 600);
        chk_int("t3_beats", dut_beats[0] - b0, 16);
        chk_int("t3_done", dut_done[0] - d0, 1);

        // Overflow on ch1: one burst parked in REQ, then five pushes into four slots.
        arb_mode = 0; gnt_v[0] = 0; gnt_v[1] = 0; bprob[1] = 100;
        d1 = dut_done[1];
        push_v[1] = 1; len_v[1] = 4'd2;
        step();
        repeat (2) step();
        for (int i = 0; i < 5; i++) begin
            push_v[1] = 1; len_v[1] = LEN_W'(i + 1);
            step();
            if (i == 3) chk("t4_full_after4", full1, 1'b1);
        end
        chk("t4_err", err1, 1'b1);
        arb_mode = 1;
        wait_idle(1, 300);
        chk_int("t4_done", dut_done[1] - d1, 5);

        // Reset in the middle of a 5-beat burst with more commands queued.
        bprob[0] = 100;
        push_v[0] = 1; len_v[0] = 4'd5;
        step();
        push_v[0] = 1; len_v[0] = 4'd3;
        step();
        b0 = dut_beats[0];
        k = 0;
        while ((dut_beats[0] - b0) < 2 && k < 20) begin
            step();
            k++;
        end
        chk("t5_beat_bound", k < 20, 1'b1);
        async_reset(3);
        repeat (4) step();
        chk("t5_queue_empty", req0, 1'b0);
        d0 = dut_done[0];
        push_v[0] = 1; len_v[0] = 4'd1;
        step();
        wait_idle(0, 50);
        chk_int("t5_done_after", dut_done[0] - d0, 1);

        // Concurrent bursts with serialized grants, then a spurious grant on idle ch1.
        arb_mode = 2; owner = -1; bprob[0] = 70; bprob[1] = 70;
        d0 = dut_done[0]; d1 = dut_done[1];
        push_v[0] = 1; len_v[0] = 4'd3;
        push_v[1] = 1; len_v[1] = 4'd4;
        step();
        wait_idle(0, 100);
        wait_idle(1, 100);
        chk_int("t6_done0", dut_done[0] - d0, 1);
        chk_int("t6_done1", dut_done[1] - d1, 1);
        arb_mode = 0; gnt_v[0] = 0; gnt_v[1] = 1;
        step();
        gnt_v[1] = 0;
        step();
        chk("t6_err1", err1, 1'b1);
        chk("t6_err0", err0, 1'b0);

        // Grant held through RELEASE on ch0 trips the watchdog on the third cycle.
        bprob[0] = 100;
        push_v[0] = 1; len_v[0] = 4'd1;
        step();
        step();
        gnt_v[0] = 1;
        step();
        chk("t7_done", done0, 1'b1);
        repeat (2) step();
        chk("t7_err_early", err0, 1'b0);
        step();
        chk("t7_err", err0, 1'b1);
        gnt_v[0] = 0;
        step();

        // Random traffic on both channels under serialized grants.
        async_reset(2);
        arb_mode = 2; owner = -1; bprob[0] = 60; bprob[1] = 60;
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < 2; c++) begin
                push_v[c] = ($urandom_range(0, 99) < 20);
                len_v[c] = LEN_W'($urandom_range(0, 15));
            end
            step();
        end
        wait_idle(0, 3000);
        wait_idle(1, 3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
